// File: rtl/alu_ctrl_pkg.sv
// alu_ctrl_pkg: ALU op codes, funct codes, aluop codes and sequencer states for alu_control_mc
package alu_ctrl_pkg;
  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_SLL = 4'b1000;
  localparam logic [3:0] ALU_SRL = 4'b1001;
  localparam logic [3:0] ALU_NOR = 4'b1100;
  localparam logic [5:0] FUNCT_SLL   = 6'b000000;
  localparam logic [5:0] FUNCT_SRL   = 6'b000010;
  localparam logic [5:0] FUNCT_MFHI  = 6'b010000;
  localparam logic [5:0] FUNCT_MFLO  = 6'b010010;
  localparam logic [5:0] FUNCT_MULT  = 6'b011000;
  localparam logic [5:0] FUNCT_MULTU = 6'b011001;
  localparam logic [5:0] FUNCT_DIV   = 6'b011010;
  localparam logic [5:0] FUNCT_DIVU  = 6'b011011;
  localparam logic [5:0] FUNCT_ADD   = 6'b100000;
  localparam logic [5:0] FUNCT_ADDU  = 6'b100001;
  localparam logic [5:0] FUNCT_SUB   = 6'b100010;
  localparam logic [5:0] FUNCT_SUBU  = 6'b100011;
  localparam logic [5:0] FUNCT_AND   = 6'b100100;
  localparam logic [5:0] FUNCT_OR    = 6'b100101;
  localparam logic [5:0] FUNCT_NOR   = 6'b100111;
  localparam logic [5:0] FUNCT_SLT   = 6'b101010;
  localparam logic [1:0] AOP_ADD   = 2'b00;
  localparam logic [1:0] AOP_SUB   = 2'b01;
  localparam logic [1:0] AOP_RTYPE = 2'b10;
  localparam logic [1:0] AOP_OR    = 2'b11;
  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;
endpackage

// File: rtl/alu_ctrl_decode.sv
// alu_ctrl_decode: aluop/funct to 4-bit ALU op plus mult/div and (ALUCTL_ILLEGAL_TRAP_EN) illegal-funct classifier
module alu_ctrl_decode
  import alu_ctrl_pkg::*;
(
  input  logic [1:0] aluop,
  input  logic [5:0] funct,
  output logic [3:0] ctrl,
  output logic       is_md
`ifdef ALUCTL_ILLEGAL_TRAP_EN
  , output logic     is_illegal
`endif
);
`ifdef ALUCTL_ILLEGAL_TRAP_EN
  localparam logic [3:0] ALU_UNK = ALU_AND;
  assign is_illegal = aluop == AOP_RTYPE && !(funct inside {FUNCT_ADD, FUNCT_ADDU, FUNCT_SUB, FUNCT_SUBU,
    FUNCT_AND, FUNCT_OR, FUNCT_SLT, FUNCT_NOR, FUNCT_SLL, FUNCT_SRL, FUNCT_MULT, FUNCT_MULTU,
    FUNCT_DIV, FUNCT_DIVU, FUNCT_MFHI, FUNCT_MFLO});
`else
  localparam logic [3:0] ALU_UNK = ALU_ADD;
`endif
  logic [3:0] rtype;
  always_comb begin
    rtype = ALU_UNK;
    case (funct)
      FUNCT_ADD, FUNCT_ADDU: rtype = ALU_ADD;
      FUNCT_SUB, FUNCT_SUBU: rtype = ALU_SUB;
      FUNCT_AND:             rtype = ALU_AND;
      FUNCT_OR:              rtype = ALU_OR;
      FUNCT_SLT:             rtype = ALU_SLT;
      FUNCT_NOR:             rtype = ALU_NOR;
      FUNCT_SLL:             rtype = ALU_SLL;
      FUNCT_SRL:             rtype = ALU_SRL;
      FUNCT_MULT, FUNCT_MULTU, FUNCT_DIV, FUNCT_DIVU, FUNCT_MFHI, FUNCT_MFLO: rtype = ALU_ADD;
      default:               rtype = ALU_UNK;
    endcase
  end
  assign ctrl = aluop == AOP_ADD ? ALU_ADD : aluop == AOP_SUB ? ALU_SUB : aluop == AOP_OR ? ALU_OR : rtype;
  assign is_md = aluop == AOP_RTYPE && funct[5:2] == 4'b0110;
endmodule

// File: rtl/alu_control_mc.sv
// alu_control_mc: ALU control decode plus MULT/DIV stall sequencer with HI/LO write pulse (optional illegal output via ALUCTL_ILLEGAL_TRAP_EN)
module alu_control_mc
  import alu_ctrl_pkg::*;
#(
  parameter int CTRL_W     = 4,
  parameter int MUL_CYCLES = 4,
  parameter int DIV_CYCLES = 32,
  parameter int CNT_W      = 6
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              valid,
  input  logic [1:0]        aluop,
  input  logic [5:0]        funct,
  output logic [CTRL_W-1:0] controlline,
  output logic              md_start,
  output logic [1:0]        md_op,
  output logic              stall,
  output logic              hilo_we
`ifdef ALUCTL_ILLEGAL_TRAP_EN
  , output logic            illegal
`endif
);
  localparam logic [CNT_W-1:0] MUL_N = CNT_W'(MUL_CYCLES - 1);
  localparam logic [CNT_W-1:0] DIV_N = CNT_W'(DIV_CYCLES - 1);
  logic [3:0] ctrl;
  logic is_md, start;
  logic [CNT_W-1:0] cnt;
  state_t state, next;
`ifdef ALUCTL_ILLEGAL_TRAP_EN
  logic is_illegal;
  alu_ctrl_decode u_dec (.aluop(aluop), .funct(funct), .ctrl(ctrl), .is_md(is_md), .is_illegal(is_illegal));
  always_ff @(posedge clk) illegal <= reset ? 1'b0 : valid & is_illegal;
`else
  alu_ctrl_decode u_dec (.aluop(aluop), .funct(funct), .ctrl(ctrl), .is_md(is_md));
`endif
  assign controlline = CTRL_W'(ctrl);
  assign start = valid & is_md & (state == S_IDLE) & ~reset;
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
      cnt   <= '0;
      md_op <= '0;
    end else begin
      state <= next;
      if (start) begin
        cnt   <= funct[1] ? DIV_N : MUL_N;
        md_op <= funct[1:0];
      end else if (state == S_BUSY) cnt <= cnt - 1'b1;
    end
  end
  always_comb begin
    next     = state;
    stall    = 1'b0;
    md_start = 1'b0;
    hilo_we  = 1'b0;
    case (state)
      S_IDLE: begin
        stall    = start;
        md_start = start;
        next     = start ? S_BUSY : S_IDLE;
      end
      S_BUSY: begin
        stall = ~reset;
        next  = cnt == CNT_W'(1) ? S_DONE : S_BUSY;
      end
      S_DONE: begin
        hilo_we = ~reset;
        next    = S_IDLE;
      end
      default: next = S_IDLE;
    endcase
  end
endmodule

// File: tb/tb_alu_control_mc.sv
// tb_alu_control_mc: scoreboard bench for alu_control_mc, per-cycle expected records checked by a negedge monitor
module tb_alu_control_mc;
  logic clk = 1'b0, reset = 1'b1, valid = 1'b0;
  logic [1:0] aluop = 2'b00;
  logic [5:0] funct = 6'b000000;
  logic [3:0] controlline;
  logic md_start, stall, hilo_we;
  logic [1:0] md_op;
`ifdef ALUCTL_ILLEGAL_TRAP_EN
  logic illegal;
  localparam logic [3:0] UNK_CL = 4'b0000;
  localparam logic ILL = 1'b1;
`else
  localparam logic [3:0] UNK_CL = 4'b0010;
  localparam logic ILL = 1'b0;
`endif
  typedef struct packed {
    logic [3:0] cl;
    logic       ms;
    logic [1:0] mo;
    logic       st;
    logic       we;
    logic       il;
  } exp_t;
  exp_t q[$];
  string nq[$];
  exp_t e;
  string n;
  int errors = 0, checks = 0;
  logic [1:0] mo_e = 2'b00;
  alu_control_mc dut (
    .clk(clk), .reset(reset), .valid(valid), .aluop(aluop), .funct(funct),
    .controlline(controlline), .md_start(md_start), .md_op(md_op), .stall(stall), .hilo_we(hilo_we)
`ifdef ALUCTL_ILLEGAL_TRAP_EN
    , .illegal(illegal)
`endif
  );
  always #5 clk = ~clk;
  task automatic chk(input string nm, input string f, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s.%s got=%0h expected=%0h", nm, f, act, exp);
    end
  endtask
  always @(negedge clk) begin
    if (q.size() > 0) begin
      e = q.pop_front();
      n = nq.pop_front();
      chk(n, "controlline", controlline, e.cl);
      chk(n, "md_start", {3'b0, md_start}, {3'b0, e.ms});
      chk(n, "md_op", {2'b0, md_op}, {2'b0, e.mo});
      chk(n, "stall", {3'b0, stall}, {3'b0, e.st});
      chk(n, "hilo_we", {3'b0, hilo_we}, {3'b0, e.we});
`ifdef ALUCTL_ILLEGAL_TRAP_EN
      chk(n, "illegal", {3'b0, illegal}, {3'b0, e.il});
`endif
    end
  end
  task automatic cyc(input logic r, input logic v, input logic [1:0] op, input logic [5:0] fn,
                     input logic [3:0] cl, input logic ms, input logic st, input logic we,
                     input logic il, input string nm);
    @(posedge clk);
    #1;
    reset = r;
    valid = v;
    aluop = op;
    funct = fn;
    q.push_back('{cl, ms, mo_e, st, we, il});
    nq.push_back(nm);
  endtask
  task automatic nop(input string nm);
    cyc(1'b0, 1'b0, 2'b00, 6'b000000, 4'b0010, 1'b0, 1'b0, 1'b0, 1'b0, nm);
  endtask
  task automatic md_run(input logic [5:0] fn, input int n_cyc, input logic [1:0] mo, input string tag);
    cyc(1'b0, 1'b1, 2'b10, fn, 4'b0010, 1'b1, 1'b1, 1'b0, 1'b0, {tag, "_start"});
    mo_e = mo;
    for (int c = 1; c < n_cyc; c++)
      cyc(1'b0, 1'b1, 2'b10, fn, 4'b0010, 1'b0, 1'b1, 1'b0, 1'b0, $sformatf("%s_busy%0d", tag, c));
    cyc(1'b0, 1'b1, 2'b10, fn, 4'b0010, 1'b0, 1'b0, 1'b1, 1'b0, {tag, "_done"});
  endtask
  initial begin
    cyc(1'b1, 1'b0, 2'b00, 6'b000000, 4'b0010, 1'b0, 1'b0, 1'b0, 1'b0, "reset0");
    cyc(1'b1, 1'b1, 2'b10, 6'b011010, 4'b0010, 1'b0, 1'b0, 1'b0, 1'b0, "reset_div_gated");
    cyc(1'b0, 1'b1, 2'b00, 6'b101010, 4'b0010, 1'b0, 1'b0, 1'b0, 1'b0, "aop00");
    cyc(1'b0, 1'b1, 2'b01, 6'b100100, 4'b0110, 1'b0, 1'b0, 1'b0, 1'b0, "aop01");
    cyc(1'b0, 1'b1, 2'b11, 6'b011000, 4'b0001, 1'b0, 1'b0, 1'b0, 1'b0, "aop11_no_start");
    cyc(1'b0, 1'b1, 2'b10, 6'b100000, 4'b0010, 1'b0, 1'b0, 1'b0, 1'b0, "add");
    cyc(1'b0, 1'b1, 2'b10, 6'b100011, 4'b0110, 1'b0, 1'b0, 1'b0, 1'b0, "subu");
    cyc(1'b0, 1'b1, 2'b10, 6'b100100, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, "and");
    cyc(1'b0, 1'b1, 2'b10, 6'b100101, 4'b0001, 1'b0, 1'b0, 1'b0, 1'b0, "or");
    cyc(1'b0, 1'b1, 2'b10, 6'b101010, 4'b0111, 1'b0, 1'b0, 1'b0, 1'b0, "slt");
    cyc(1'b0, 1'b1, 2'b10, 6'b100111, 4'b1100, 1'b0, 1'b0, 1'b0, 1'b0, "nor");
    cyc(1'b0, 1'b1, 2'b10, 6'b000000, 4'b1000, 1'b0, 1'b0, 1'b0, 1'b0, "sll");
    cyc(1'b0, 1'b1, 2'b10, 6'b000010, 4'b1001, 1'b0, 1'b0, 1'b0, 1'b0, "srl");
    cyc(1'b0, 1'b1, 2'b10, 6'b010010, 4'b0010, 1'b0, 1'b0, 1'b0, 1'b0, "mflo");
    cyc(1'b0, 1'b1, 2'b10, 6'b111111, UNK_CL, 1'b0, 1'b0, 1'b0, 1'b0, "unk");
    cyc(1'b0, 1'b0, 2'b10, 6'b111111, UNK_CL, 1'b0, 1'b0, 1'b0, ILL, "unk_invalid");
    cyc(1'b0, 1'b0, 2'b10, 6'b011000, 4'b0010, 1'b0, 1'b0, 1'b0, 1'b0, "mult_invalid");
    nop("idle0");
    md_run(6'b011011, 32, 2'b11, "divu");
    nop("divu_idle");
    cyc(1'b0, 1'b1, 2'b10, 6'b011010, 4'b0010, 1'b1, 1'b1, 1'b0, 1'b0, "div_start");
    mo_e = 2'b10;
    for (int c = 1; c < 10; c++)
      cyc(1'b0, 1'b1, 2'b10, 6'b011010, 4'b0010, 1'b0, 1'b1, 1'b0, 1'b0, $sformatf("div_busy%0d", c));
    cyc(1'b1, 1'b1, 2'b10, 6'b011010, 4'b0010, 1'b0, 1'b0, 1'b0, 1'b0, "div_abort");
    mo_e = 2'b00;
    for (int c = 0; c < 40; c++) nop($sformatf("post_abort%0d", c));
    md_run(6'b011001, 4, 2'b01, "multu");
    nop("multu_idle");
    md_run(6'b011001, 4, 2'b01, "b2b_a");
    md_run(6'b011000, 4, 2'b00, "b2b_b");
    nop("b2b_idle");
    for (int i = 0; i < 5 && q.size() > 0; i++) @(negedge clk);
    #1;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain got=%0d expected=0 pending records", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
